// File: rtl/mii_net_tx_frame_ctrl.sv
// -----------------------------------------------------------------------------
// mii_net_tx_frame_ctrl
//
// Transmit frame sequencer for the MII Ethernet path. Turns a byte stream from
// the MAC client into a complete wire frame for the nibble serializer:
// preamble, SFD, payload, zero pad up to the minimum length, FCS, and then the
// inter-frame gap. It steers an external CRC-32 engine (init / fold / shift)
// and aborts the frame with an errored byte if the client underruns.
//
// Ports
//   i_clk, i_reset      clock, asynchronous active-high reset
//   i_data/i_valid/i_last/o_ready
//                       client byte stream (byte taken when i_valid && o_ready)
//   o_tx_data/o_tx_en/o_tx_er, i_tx_ready
//                       byte towards the serializer; one byte-time is consumed
//                       in each cycle with i_tx_ready=1
//   o_crc_d/o_crc_d_valid/o_crc_calc/o_crc_init, i_crc
//                       CRC engine control; i_crc is the engine's current FCS
//                       output byte
//   o_busy              sequencer not idle
//   o_frame_done        pulse when the last FCS byte is consumed
//   o_underrun          pulse when a frame is aborted for lack of data
// -----------------------------------------------------------------------------
module mii_net_tx_frame_ctrl #(
  parameter int PREAMBLE_LEN = 7,
  parameter int MIN_FRAME    = 60,
  parameter int IFG_LEN      = 12
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  input  logic       i_last,
  output logic       o_ready,
  output logic [7:0] o_tx_data,
  output logic       o_tx_en,
  output logic       o_tx_er,
  input  logic       i_tx_ready,
  output logic [7:0] o_crc_d,
  output logic       o_crc_d_valid,
  output logic       o_crc_calc,
  output logic       o_crc_init,
  input  logic [7:0] i_crc,
  output logic       o_busy,
  output logic       o_frame_done,
  output logic       o_underrun
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_SFD,
    S_DATA,
    S_PAD,
    S_FCS,
    S_DRAIN,
    S_IFG
  } state_t;

  localparam logic [15:0] PRE_LAST = 16'(PREAMBLE_LEN - 1);
  localparam logic [15:0] MIN_LEN  = 16'(MIN_FRAME);
  localparam logic [15:0] IFG_LAST = 16'(IFG_LEN - 1);
  localparam logic [15:0] FCS_LAST = 16'd3;

  state_t      state_q, state_d;
  // Shared counter: preamble bytes, frame byte count (DATA/PAD), FCS bytes,
  // IFG ticks. Every state entry that uses it starts it from zero.
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] cnt_inc;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Saturating so an oversized frame never wraps back under MIN_FRAME.
  assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

  assign o_busy = (state_q != S_IDLE);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    o_ready       = 1'b0;
    o_tx_data     = 8'h00;
    o_tx_en       = 1'b0;
    o_tx_er       = 1'b0;
    o_crc_d       = 8'h00;
    o_crc_d_valid = 1'b0;
    o_crc_calc    = 1'b0;
    o_crc_init    = 1'b0;
    o_frame_done  = 1'b0;
    o_underrun    = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Gated by reset so every output reads zero while reset is held.
        if (i_valid && !i_reset) begin
          o_crc_init = 1'b1;
          state_d    = S_PREAMBLE;
          cnt_d      = 16'd0;
        end
      end

      S_PREAMBLE: begin
        o_tx_en   = 1'b1;
        o_tx_data = 8'h55;
        if (i_tx_ready) begin
          if (cnt_q == PRE_LAST) begin
            state_d = S_SFD;
            cnt_d   = 16'd0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end

      S_SFD: begin
        o_tx_en   = 1'b1;
        o_tx_data = 8'hD5;
        if (i_tx_ready) begin
          state_d = S_DATA;
          cnt_d   = 16'd0;
        end
      end

      S_DATA: begin
        o_tx_en    = 1'b1;
        o_ready    = i_tx_ready;
        o_crc_calc = 1'b1;
        if (i_valid) begin
          o_tx_data = i_data;
          o_crc_d   = i_data;
        end else begin
          // No byte available: the slot goes out as an errored zero byte.
          o_tx_er = 1'b1;
        end
        if (i_tx_ready) begin
          if (i_valid) begin
            o_crc_d_valid = 1'b1;
            cnt_d         = cnt_inc;
            if (i_last) begin
              if (cnt_inc < MIN_LEN) begin
                state_d = S_PAD;
              end else begin
                state_d = S_FCS;
                cnt_d   = 16'd0;
              end
            end
          end else begin
            o_underrun = 1'b1;
            cnt_d      = 16'd0;
            state_d    = i_last ? S_IFG : S_DRAIN;
          end
        end
      end

      S_PAD: begin
        o_tx_en    = 1'b1;
        o_crc_calc = 1'b1;
        if (i_tx_ready) begin
          o_crc_d_valid = 1'b1;
          cnt_d         = cnt_inc;
          if (cnt_inc >= MIN_LEN) begin
            state_d = S_FCS;
            cnt_d   = 16'd0;
          end
        end
      end

      S_FCS: begin
        // The engine advances to the next FCS byte the cycle after each
        // shift strobe, so i_crc always holds the byte for this slot.
        o_tx_en   = 1'b1;
        o_tx_data = i_crc;
        if (i_tx_ready) begin
          o_crc_d_valid = 1'b1;
          if (cnt_q == FCS_LAST) begin
            o_frame_done = 1'b1;
            state_d      = S_IFG;
            cnt_d        = 16'd0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end

      S_DRAIN: begin
        // Swallow the rest of the aborted frame at whatever rate it arrives.
        o_ready = 1'b1;
        if (i_valid && i_last) begin
          state_d = S_IFG;
          cnt_d   = 16'd0;
        end
      end

      S_IFG: begin
        if (i_tx_ready) begin
          if (cnt_q == IFG_LAST) begin
            state_d = S_IDLE;
            cnt_d   = 16'd0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = 16'd0;
      end
    endcase
  end

endmodule
